// File: rtl/voice_phase_bank.sv
// voice_phase_bank: round-robin bank of NBANKS voice phase accumulators with a note allocation FSM
// Ports: clk/rst (sync, active-high); clk_en gates slot counter, phase update and sample outputs;
//        i_note_valid/i_note_on/i_note_midi with o_note_ready form the note event handshake;
//        o_phase/o_midi/o_valid/o_slot describe the emitted slot; o_active is the live-slot mask;
//        o_drop pulses when a note-on finds no free slot.
module voice_phase_bank #(
  parameter int NBANKS = 10,
  parameter int FS_HZ  = 48000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              i_note_valid,
  input  logic              i_note_on,
  input  logic [6:0]        i_note_midi,
  output logic              o_note_ready,
  output logic [23:0]       o_phase,
  output logic [6:0]        o_midi,
  output logic              o_valid,
  output logic [3:0]        o_slot,
  output logic [NBANKS-1:0] o_active,
  output logic              o_drop
);
  typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;
  state_t r_state, w_next;
  logic [23:0] w_rom [128];
  logic [NBANKS-1:0] r_active;
  logic [6:0]  r_midi  [NBANKS];
  logic [23:0] r_tword [NBANKS];
  logic [23:0] r_phase [NBANKS];
  logic [3:0]  r_s, r_k, r_match_idx, r_free_idx;
  logic        r_ev_on, r_match_found, r_free_found;
  logic [6:0]  r_ev_midi;
  // Equal-tempered tuning words, A4 (note 69) = 440 Hz, folded to constants at elaboration
  for (genvar g = 0; g < 128; g++) begin : g_rom
    assign w_rom[g] = 24'($rtoi(16777216.0 * 440.0 * (2.0 ** (real'(g - 69) / 12.0)) / real'(FS_HZ) + 0.5));
  end
  always_comb begin
    w_next = r_state == IDLE ? (i_note_valid ? SCAN : IDLE) :
             r_state == SCAN ? (r_k == 4'(NBANKS - 1) ? APPLY : SCAN) : IDLE;
    o_note_ready = r_state == IDLE;
    o_drop = r_state == APPLY && r_ev_on && !r_match_found && !r_free_found;
    o_active = r_active;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_s <= '0;
      r_k <= '0;
      r_active <= '0;
      r_ev_on <= 1'b0;
      r_ev_midi <= '0;
      r_match_found <= 1'b0;
      r_free_found <= 1'b0;
      r_match_idx <= '0;
      r_free_idx <= '0;
      o_phase <= '0;
      o_midi <= '0;
      o_valid <= 1'b0;
      o_slot <= '0;
      for (int i = 0; i < NBANKS; i++) begin
        r_midi[i] <= '0;
        r_tword[i] <= '0;
        r_phase[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (clk_en) begin
        o_slot <= r_s;
        o_valid <= r_active[r_s];
        o_phase <= r_active[r_s] ? r_phase[r_s] : '0;
        o_midi <= r_active[r_s] ? r_midi[r_s] : '0;
        if (r_active[r_s]) r_phase[r_s] <= r_phase[r_s] + r_tword[r_s];
        r_s <= r_s == 4'(NBANKS - 1) ? '0 : r_s + 4'd1;
      end
      if (r_state == IDLE && i_note_valid) begin
        r_ev_on <= i_note_on;
        r_ev_midi <= i_note_midi;
        r_match_found <= 1'b0;
        r_free_found <= 1'b0;
        r_k <= '0;
      end
      if (r_state == SCAN) begin
        if (!r_match_found && r_active[r_k] && r_midi[r_k] == r_ev_midi) begin
          r_match_found <= 1'b1;
          r_match_idx <= r_k;
        end
        if (!r_free_found && !r_active[r_k]) begin
          r_free_found <= 1'b1;
          r_free_idx <= r_k;
        end
        r_k <= r_k + 4'd1;
      end
      // Placed after the emission update so a same-cycle write to the emitted slot wins
      if (r_state == APPLY) begin
        if (r_ev_on && r_match_found) r_phase[r_match_idx] <= '0;
        else if (r_ev_on && r_free_found) begin
          r_active[r_free_idx] <= 1'b1;
          r_midi[r_free_idx] <= r_ev_midi;
          r_tword[r_free_idx] <= w_rom[r_ev_midi];
          r_phase[r_free_idx] <= '0;
        end else if (!r_ev_on && r_match_found) r_active[r_match_idx] <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_voice_phase_bank.sv
// tb_voice_phase_bank: scoreboard bench for voice_phase_bank against a slot-array reference model
module tb_voice_phase_bank;
  localparam int NB = 10;
  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b0, nv = 1'b0, non = 1'b0;
  logic [6:0] nm = '0;
  logic o_note_ready, o_valid, o_drop;
  logic [23:0] o_phase;
  logic [6:0] o_midi;
  logic [3:0] o_slot;
  logic [NB-1:0] o_active;
  always #5 clk = ~clk;
  voice_phase_bank #(.NBANKS(NB), .FS_HZ(48000)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_note_valid(nv), .i_note_on(non), .i_note_midi(nm),
    .o_note_ready(o_note_ready), .o_phase(o_phase), .o_midi(o_midi), .o_valid(o_valid),
    .o_slot(o_slot), .o_active(o_active), .o_drop(o_drop));
  typedef struct packed {logic [23:0] ph; logic [6:0] mi; logic v; logic [3:0] sl;} samp_t;
  samp_t q[$];
  samp_t last = '0;
  int checks = 0, failures = 0;
  bit started = 0;
  bit m_act[NB];
  logic [6:0] m_midi[NB];
  logic [23:0] m_ph[NB], m_tw[NB];
  int m_s = 0, cnt = 0, ev_midi = 0;
  bit ev_on = 0, m_drop = 0;
  int rom[128];
  initial for (int n = 0; n < 128; n++)
    rom[n] = $rtoi(16777216.0 * 440.0 * (2.0 ** (real'(n - 69) / 12.0)) / 48000.0 + 0.5);
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction
  function automatic int find_match(int mid);
    for (int i = 0; i < NB; i++) if (m_act[i] && int'(m_midi[i]) == mid) return i;
    return -1;
  endfunction
  function automatic int find_free();
    for (int i = 0; i < NB; i++) if (!m_act[i]) return i;
    return -1;
  endfunction
  // Reference model: event applied NB+1 edges after acceptance, after that edge's emission
  always @(posedge clk) begin
    int old, mt, fr;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_act[i] = 0; m_midi[i] = '0; m_ph[i] = '0; m_tw[i] = '0;
      end
      m_s = 0; cnt = 0; ev_on = 0;
      q.delete();
      q.push_back('0);
      started = 1;
    end else begin
      if (clk_en) begin
        q.push_back({m_act[m_s] ? m_ph[m_s] : 24'd0, m_act[m_s] ? m_midi[m_s] : 7'd0, m_act[m_s], 4'(m_s)});
        if (m_act[m_s]) m_ph[m_s] = m_ph[m_s] + m_tw[m_s];
        m_s = (m_s + 1) % NB;
      end
      if (cnt == 1) begin
        mt = find_match(ev_midi);
        fr = find_free();
        if (ev_on && mt >= 0) m_ph[mt] = '0;
        else if (ev_on && fr >= 0) begin
          m_act[fr] = 1; m_midi[fr] = 7'(ev_midi); m_tw[fr] = 24'(rom[ev_midi]); m_ph[fr] = '0;
        end else if (!ev_on && mt >= 0) m_act[mt] = 0;
      end
      old = cnt;
      if (cnt > 0) cnt--;
      if (old == 0 && nv) begin
        cnt = NB + 1; ev_on = non; ev_midi = int'(nm);
      end
    end
    m_drop = cnt == 1 && ev_on && find_match(ev_midi) < 0 && find_free() < 0;
  end
  always @(negedge clk) if (started) begin
    logic [NB-1:0] am;
    if (q.size() > 0) last = q.pop_front();
    for (int i = 0; i < NB; i++) am[i] = m_act[i];
    chk("phase", 32'(o_phase), 32'(last.ph));
    chk("midi", 32'(o_midi), 32'(last.mi));
    chk("valid", 32'(o_valid), 32'(last.v));
    chk("slot", 32'(o_slot), 32'(last.sl));
    chk("active", 32'(o_active), 32'(am));
    chk("ready", 32'(o_note_ready), 32'(cnt == 0));
    chk("drop", 32'(o_drop), 32'(m_drop));
  end
  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(bit on, int m);
    int n = 0;
    while (!o_note_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    nv = 1; non = on; nm = 7'(m);
    @(negedge clk);
    nv = 0;
  endtask
  initial begin
    int got;
    logic [23:0] p2;
    p2 = '0;
    idle(3);
    rst = 0; clk_en = 1;
    idle(30);
    send(1, 69);
    got = 0;
    for (int k = 0; k < 60 && got < 2; k++) begin
      @(negedge clk);
      if (o_valid && o_slot == 4'd0) begin got++; p2 = o_phase; end
    end
    if (got < 2) begin
      checks++; failures++;
      $display("FAIL slot0_emit_timeout actual=%0d required=2", got);
    end else chk("tword69", 32'(p2), 32'd153791);
    chk("act_one", 32'(o_active), 32'h1);
    for (int m = 60; m < 69; m++) send(1, m);
    idle(12);
    chk("act_full", 32'(o_active), 32'h3FF);
    send(1, 100);
    idle(14);
    chk("act_after_drop", 32'(o_active), 32'h3FF);
    send(0, 64);
    idle(25);
    send(1, 69);
    idle(12);
    send(0, 70);
    idle(25);
    clk_en = 0;
    send(0, 61);
    send(1, 90);
    idle(5);
    clk_en = 1;
    idle(20);
    send(1, 50);
    idle(3);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_ready", 32'(o_note_ready), 32'h1);
    chk("rst_active", 32'(o_active), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    idle(15);
    chk("rst_no_alloc", 32'(o_active), 32'h0);
    repeat (1500) begin
      clk_en = $urandom_range(0, 3) != 0;
      nv = $urandom_range(0, 3) == 0;
      non = $urandom_range(0, 2) != 0;
      nm = 7'(40 + $urandom_range(0, 13));
      rst = $urandom_range(0, 499) == 0;
      @(negedge clk);
    end
    nv = 0; rst = 0; clk_en = 1;
    idle(20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/voice_phase_bank.md
VOICE_PHASE_BANK -- requirements
Module: voice_phase_bank

Interface
REQ-001 Parameter NBANKS, default 10, is the number of voice slots served round-robin.
REQ-002 Parameter FS_HZ, default 48000, is the sample rate used for tuning-word generation.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 clk_en  in  1  sample-slot enable; gates the slot counter, phase update and the o_* sample outputs.
REQ-006 i_note_valid  in  1  note event request.
REQ-007 i_note_on  in  1  1 = note-on, 0 = note-off.
REQ-008 i_note_midi  in  7  MIDI note number of the event.
REQ-009 o_note_ready  out  1  event accept; transfer occurs on an edge where i_note_valid && o_note_ready.
REQ-010 o_phase  out  24  phase of the emitted slot; feeds the sine stage phase input.
REQ-011 o_midi  out  7  MIDI note of the emitted slot.
REQ-012 o_valid  out  1  emitted slot is active.
REQ-013 o_slot  out  4  index of the emitted slot.
REQ-014 o_active  out  NBANKS  active-slot mask; bit k = slot k active.
REQ-015 o_drop  out  1  one-cycle pulse when a note-on finds no free slot.

Function
REQ-016 Internal 128x24 tuning ROM entry n SHALL equal round(2^24 * 440 * 2^((n-69)/12) / FS_HZ); n=69 at 48000 -> 153791.
REQ-017 Per-slot state SHALL be: active bit, 7-bit midi, 24-bit tuning word, 24-bit phase.
REQ-018 Slot counter s SHALL advance 0..NBANKS-1 and wrap to 0, once per clk cycle with clk_en=1; it SHALL hold when clk_en=0.
REQ-019 On a clk_en=1 edge, if slot s is active: o_phase <= phase[s] (pre-increment), o_midi <= midi[s], o_valid <= 1, o_slot <= s, and phase[s] <= (phase[s] + tword[s]) mod 2^24.
REQ-020 On a clk_en=1 edge, if slot s is inactive: o_phase <= 0, o_midi <= 0, o_valid <= 0, o_slot <= s, and phase[s] is unchanged.
REQ-021 With clk_en=0, o_phase, o_midi, o_valid, o_slot and all phases SHALL hold.
REQ-022 The event FSM SHALL have states IDLE, SCAN and APPLY, and SHALL run every clk cycle regardless of clk_en.
REQ-023 IDLE: o_note_ready=1; on acceptance, latch on/midi, clear the match and free flags, set k=0, and go to SCAN.
REQ-024 SCAN: examine one slot k per cycle, recording the first k with (active && midi==latched) and the first k with !active; go to APPLY after k=NBANKS-1.
REQ-025 APPLY: perform the action below, then go to IDLE; o_note_ready SHALL be 0 for exactly NBANKS+1 cycles after acceptance.
REQ-026 Note-on with a match: phase[match] <= 0 (retrigger); active mask unchanged.
REQ-027 Note-on with no match and a free slot: the lowest free slot gets active=1, midi, tword=ROM[midi] and phase=0.
REQ-028 Note-on with no match and no free slot: no state change; o_drop=1 for the APPLY cycle only.
REQ-029 Note-off with a match: active[match] <= 0. Note-off with no match: no change.
REQ-030 If APPLY writes the slot being emitted in the same cycle, the APPLY write SHALL win for phase/active/midi/tword; the sample outputs for that cycle SHALL use the pre-APPLY values.
REQ-031 o_active SHALL reflect the registered active bits with zero added latency.

Reset
REQ-032 rst=1 on an edge SHALL set: all slot active, phase, midi and tword to 0; s=0; FSM to IDLE; o_phase=0; o_midi=0; o_valid=0; o_slot=0; o_active=0; o_drop=0; o_note_ready=1.
REQ-033 rst SHALL override clk_en and any in-progress SCAN or APPLY; the latched event is discarded.

Verification
REQ-034 Reset, then 30 cycles with clk_en=1 and no events -> o_valid=0 throughout, o_active=0, o_note_ready=1, o_slot cycles 0..9.
REQ-035 Note-on 69 accepted at cycle t -> o_note_ready low for 11 cycles, o_active=0x001; with clk_en=1, slot 0 emits o_valid=1, o_midi=69, o_phase 0, 153791, 307582, ... every 10 cycles.
REQ-036 Note-on of 10 distinct notes, then note-on 100 -> o_active=0x3FF, o_drop pulses once, mask unchanged; note-off of a held note clears exactly its bit and that slot then emits o_valid=0.
REQ-037 Repeat note-on 69 while held -> slot 0 phase restarts at 0; no second slot is allocated; note-off 70 (not held) -> no change.
REQ-038 Hold clk_en=0 for 5 cycles mid-run -> all outputs and phases frozen; the event FSM still completes and the new slot becomes active.
REQ-039 Assert rst during SCAN -> next cycle o_note_ready=1, o_active=0, o_valid=0, and no slot is allocated.
